mux_seq_gen: RTL and testbench
==============================

// Module: mux_seq_gen
// PURPOSE
//  Upstream sequencer for the mux decoder stage: on each line_start it steps the panel
//  source-mux through 1..4 phases, driving phase code {da,db} plus a mux_en strobe.
//  Programmable setup, on-time and inter-phase gap, with forward or reverse scan order.
//  The decoder downstream registers {da,db}, so the code is driven during SETUP/GAP and
//  held stable for the whole ACTIVE window.
// PARAMETERS
//  CNT_W    12   width of timing counters and of t_setup/t_on/t_gap
// PORTS
//  clk         in   1      system clock; one clock domain
//  rst         in   1      reset, synchronous, active-high
//  line_start  in   1      1-cycle pulse, start of one line's mux sequence
//  t_setup     in   CNT_W  cycles from start to first ACTIVE (0 = no setup)
//  t_on        in   CNT_W  mux_en high cycles per phase (0 treated as 1)
//  t_gap       in   CNT_W  dead cycles between phases (0 = back-to-back)
//  mux_num     in   3      phases per line; 0 -> 1, >4 -> 4
//  reverse     in   1      0: codes 0,1,..,N-1; 1: codes N-1,..,0
//  da          out  1      phase code MSB
//  db          out  1      phase code LSB
//  mux_en      out  1      high during ACTIVE windows only
//  busy        out  1      high from the cycle after accepted start through DONE
//  done        out  1      1-cycle pulse, sequence complete
//  overrun     out  1      1-cycle pulse, line_start received while busy
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE, da=db=0, mux_en=0, busy=0, done=0,
//    overrun=0, counters=0. Reset mid-sequence aborts immediately, no done pulse.
//  - t_setup/t_on/t_gap/mux_num/reverse are latched on the accepted line_start;
//    later changes take effect on the next line only.
//  - FSM IDLE -> SETUP -> ACTIVE -> (GAP -> ACTIVE)* -> DONE -> IDLE.
//  - IDLE: line_start -> SETUP (or ACTIVE if t_setup=0) at cycle+1. da/db load first code.
//  - SETUP: t_setup cycles, mux_en=0, da/db = first code.
//  - ACTIVE: t_on cycles, mux_en=1, da/db constant. At the end: last phase -> DONE;
//    otherwise GAP (t_gap>0) or the next ACTIVE directly (t_gap=0).
//  - GAP: t_gap cycles, mux_en=0. da/db update to the next code in the first GAP cycle.
//    With t_gap=0, the code changes in the same cycle the next ACTIVE starts.
//  - DONE: 1 cycle, done=1, busy=1, mux_en=0, da/db hold the last code. Then IDLE, busy=0.
//  - Phase code k (0-based): forward {da,db}=k[1:0]; reverse {da,db}=(N-1-k)[1:0].
//  - line_start in any non-IDLE state is ignored and pulses overrun next cycle. A start
//    in the DONE cycle is also ignored.
//  - Total busy cycles = t_setup + N*t_on' + (N-1)*t_gap + 1, where t_on' = max(t_on,1).
//  - Down-counters load (value-1) on state entry. No wrap: max CNT_W value is legal.
// STRUCTURE
//  - Shared package mux_pkg: state encoding localparams (IDLE,SETUP,ACTIVE,GAP,DONE),
//    MUX_MAX=4, and the phase-code width (2).
//  - One sub-module, mux_seq_cnt: loadable CNT_W down-counter with a zero flag, used
//    for all timing intervals. FSM and phase index stay in mux_seq_gen.
// TESTING
//  1. Reset then idle: all outputs 0 for 20 cycles. No line_start -> no activity.
//  2. t_setup=2, t_on=3, t_gap=1, N=2, fwd, start@c0 -> busy c1-c10, mux_en c3-5 code 00
//     and c7-9 code 01, gap c6 shows 01, done@c10, busy=0@c11.
//  3. N=4, reverse=1, t_setup=0, t_gap=0, t_on=2 -> codes 11,10,01,00, 2 cycles each,
//     mux_en high continuously for 8 cycles from c1, done@c9.
//  4. Edge values: t_on=0, mux_num=0 -> exactly 1 mux_en cycle. mux_num=7 -> 4 phases.
//  5. line_start during ACTIVE -> overrun pulse next cycle, sequence timing unchanged.
//     Config change mid-line -> applied only on the following line.
//  6. rst asserted during GAP -> next cycle all outputs 0, state IDLE, no done.
//     A new start then runs a full sequence.

Source files
------------

// File: rtl/mux_seq_gen_pkg.sv
// Shared types and helpers for the panel mux sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mux_pkg;

  localparam int MUX_MAX = 4;  // most phases one line can step through
  localparam int CODE_W  = 2;  // width of the {da,db} phase code

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACTIVE = 3'd2,
    GAP    = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Index of the last phase: a request of 0 phases runs 1, above MUX_MAX runs MUX_MAX.
  function automatic logic [CODE_W-1:0] clamp_last(input logic [2:0] num);
    if (num == 3'd0)
      return '0;
    else if (num > 3'(MUX_MAX))
      return CODE_W'(MUX_MAX - 1);
    else
      return CODE_W'(num - 3'd1);
  endfunction

  // Code driven for phase idx. Reverse scan counts down from the last phase.
  function automatic logic [CODE_W-1:0] phase_code(input logic [CODE_W-1:0] idx,
                                                   input logic [CODE_W-1:0] last,
                                                   input logic              rev);
    return rev ? (last - idx) : idx;
  endfunction

endpackage

// File: rtl/mux_seq_gen_if.sv
// Control/status bundle between a line controller and the mux sequencer.
// Latency: n/a (wires only).
// Backpressure: none; line_start is a fire-and-forget pulse.
// Ports: line_start, t_setup, t_on, t_gap, mux_num, reverse (to sequencer);
//        da, db, mux_en, busy, done, overrun (from sequencer).
interface mux_seq_gen_if #(parameter int CNT_W = 12);

  logic             line_start;
  logic [CNT_W-1:0] t_setup;
  logic [CNT_W-1:0] t_on;
  logic [CNT_W-1:0] t_gap;
  logic [2:0]       mux_num;
  logic             reverse;
  logic             da;
  logic             db;
  logic             mux_en;
  logic             busy;
  logic             done;
  logic             overrun;

  modport master (
    output line_start, t_setup, t_on, t_gap, mux_num, reverse,
    input  da, db, mux_en, busy, done, overrun
  );

  modport slave (
    input  line_start, t_setup, t_on, t_gap, mux_num, reverse,
    output da, db, mux_en, busy, done, overrun
  );

endinterface

// File: rtl/mux_seq_cnt.sv
// Loadable down-counter timing every SETUP/ACTIVE/GAP interval.
// Latency: load takes effect next cycle; zero reflects the registered count.
// Backpressure: none; holds at zero until reloaded.
// Ports: clk, rst, load, load_val in; zero out.
module mux_seq_cnt #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Sticks at zero rather than wrapping, so a full-scale load is safe.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - CNT_W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mux_seq_gen.sv
// Steps the panel source-mux through 1..4 phases per line with setup/on/gap timing.
// Latency: first state one cycle after line_start; every output registered.
// Backpressure: none; starts while busy are dropped and flagged on overrun.
// Ports: clk, rst plain; bus (slave) carries line_start + timing config in,
//        da/db/mux_en/busy/done/overrun out.
module mux_seq_gen
  import mux_pkg::*;
#(
  parameter int CNT_W = 12
) (
  input  logic clk,
  input  logic rst,
  mux_seq_gen_if.slave bus
);

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   idx_q, idx_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CNT_W-1:0]    ton_m1_q, tgap_q;
  logic [CODE_W-1:0]   last_q;
  logic                rev_q;
  logic                mux_en_q, busy_q, done_q, overrun_q;
  logic                cnt_load, cnt_zero;
  logic [CNT_W-1:0]    cnt_val;
  logic [CNT_W-1:0]    ton_m1_in;
  logic                accept;

  // An on-time of 0 still gives one ACTIVE cycle.
  assign ton_m1_in = (bus.t_on == '0) ? '0 : bus.t_on - CNT_W'(1);
  assign accept    = (state_q == IDLE) && bus.line_start;

  mux_seq_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    code_d   = code_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state_q)
      IDLE: begin
        if (bus.line_start) begin
          idx_d    = '0;
          code_d   = phase_code('0, clamp_last(bus.mux_num), bus.reverse);
          cnt_load = 1'b1;
          if (bus.t_setup != '0) begin
            state_d = SETUP;
            cnt_val = bus.t_setup - CNT_W'(1);
          end else begin
            state_d = ACTIVE;
            cnt_val = ton_m1_in;
          end
        end
      end
      SETUP, GAP: begin
        if (cnt_zero) begin
          state_d  = ACTIVE;
          cnt_load = 1'b1;
          cnt_val  = ton_m1_q;
        end
      end
      ACTIVE: begin
        if (cnt_zero) begin
          if (idx_q == last_q) begin
            state_d = DONE;
          end else begin
            // Next code goes out with the first GAP cycle, or with the next
            // ACTIVE cycle when there is no gap; the decoder sees it settled.
            idx_d    = idx_q + CODE_W'(1);
            code_d   = phase_code(idx_q + CODE_W'(1), last_q, rev_q);
            cnt_load = 1'b1;
            if (tgap_q != '0) begin
              state_d = GAP;
              cnt_val = tgap_q - CNT_W'(1);
            end else begin
              state_d = ACTIVE;
              cnt_val = ton_m1_q;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      code_q    <= '0;
      ton_m1_q  <= '0;
      tgap_q    <= '0;
      last_q    <= '0;
      rev_q     <= 1'b0;
      mux_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      code_q    <= code_d;
      // Config is captured once per line so mid-line edits cannot skew timing.
      if (accept) begin
        ton_m1_q <= ton_m1_in;
        tgap_q   <= bus.t_gap;
        last_q   <= clamp_last(bus.mux_num);
        rev_q    <= bus.reverse;
      end
      mux_en_q  <= (state_d == ACTIVE);
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
      overrun_q <= bus.line_start && (state_q != IDLE);
    end
  end

  assign bus.da      = code_q[1];
  assign bus.db      = code_q[0];
  assign bus.mux_en  = mux_en_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_mux_seq_gen.sv
module tb_mux_seq_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_seq_gen_if #(.CNT_W(12)) bus ();

  mux_seq_gen #(.CNT_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // One line of stimulus plus the hand-derived totals it must produce.
  typedef struct {
    logic [11:0] ts;
    logic [11:0] ton;
    logic [11:0] tg;
    logic [2:0]  num;
    logic        rev;
    int          inj;       // cycle of a stray line_start, -1 for none
    int          abort_at;  // cycle in which rst is raised, -1 for none
    int          exp_busy;  // busy cycles, -1 to skip
    int          exp_en;    // mux_en cycles
  } vec_t;

  // Expected per-cycle outputs, one entry per cycle after the start.
  typedef struct {
    logic       busy;
    logic       en;
    logic       done;
    logic       ovr;
    logic       chk_code;
    logic [1:0] code;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [1:0] mcode(input int k, input int n, input logic rev);
    int c;
    c = rev ? (n - 1 - k) : k;
    return 2'(c);
  endfunction

  task automatic push_entry(input logic b, input logic e, input logic d,
                            input logic cc, input logic [1:0] c);
    exp_t x;
    x.busy = b; x.en = e; x.done = d; x.ovr = 1'b0; x.chk_code = cc; x.code = c;
    sb.push_back(x);
  endtask

  // Expected trace built straight from the phase/timing description.
  task automatic push_model(input vec_t v);
    int n, ton, ts, tg;
    n   = (v.num == 0) ? 1 : ((v.num > 4) ? 4 : int'(v.num));
    ton = (v.ton == 0) ? 1 : int'(v.ton);
    ts  = int'(v.ts);
    tg  = int'(v.tg);
    for (int i = 0; i < ts; i++) push_entry(1, 0, 0, 1, mcode(0, n, v.rev));
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < ton; i++) push_entry(1, 1, 0, 1, mcode(k, n, v.rev));
      if (k < n - 1)
        for (int i = 0; i < tg; i++) push_entry(1, 0, 0, 1, mcode(k + 1, n, v.rev));
    end
    push_entry(1, 0, 1, 1, mcode(n - 1, n, v.rev));
    push_entry(0, 0, 0, 0, 2'b00);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".busy"},    int'(bus.busy),    0);
    chk({tag, ".mux_en"},  int'(bus.mux_en),  0);
    chk({tag, ".done"},    int'(bus.done),    0);
    chk({tag, ".overrun"}, int'(bus.overrun), 0);
    chk({tag, ".code"},    int'({bus.da, bus.db}), 0);
  endtask

  task automatic run_line(input vec_t v, input int vi);
    exp_t e;
    int   nbusy, nen, ndone, i;
    string tag;
    tag = $sformatf("v%0d", vi);
    @(negedge clk);
    bus.t_setup    = v.ts;
    bus.t_on       = v.ton;
    bus.t_gap      = v.tg;
    bus.mux_num    = v.num;
    bus.reverse    = v.rev;
    bus.line_start = 1'b1;
    sb.delete();
    push_model(v);
    if (v.inj >= 0 && v.inj < sb.size()) sb[v.inj].ovr = 1'b1;
    nbusy = 0; nen = 0; ndone = 0; i = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      i++;
      e = sb.pop_front();
      chk({tag, ".busy"},    int'(bus.busy),    int'(e.busy));
      chk({tag, ".mux_en"},  int'(bus.mux_en),  int'(e.en));
      chk({tag, ".done"},    int'(bus.done),    int'(e.done));
      chk({tag, ".overrun"}, int'(bus.overrun), int'(e.ovr));
      if (e.chk_code) chk({tag, ".code"}, int'({bus.da, bus.db}), int'(e.code));
      nbusy += int'(bus.busy);
      nen   += int'(bus.mux_en);
      ndone += int'(bus.done);
      bus.line_start = 1'b0;
      if (i == v.inj) begin
        // Stray start plus a config edit; neither may touch this line.
        bus.line_start = 1'b1;
        bus.t_on       = 12'd1;
        bus.t_gap      = 12'd0;
        bus.mux_num    = 3'd1;
        bus.reverse    = ~v.rev;
      end
      if (i == v.abort_at) begin
        rst = 1'b1;
        sb.delete();
      end
    end
    bus.line_start = 1'b0;
    if (v.abort_at >= 0) begin
      @(negedge clk);
      check_all_zero({tag, ".abort"});
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk({tag, ".post_abort.done"}, int'(bus.done), 0);
        chk({tag, ".post_abort.busy"}, int'(bus.busy), 0);
      end
    end
    if (v.exp_busy >= 0) begin
      chk({tag, ".busy_total"},  nbusy, v.exp_busy);
      chk({tag, ".en_total"},    nen,   v.exp_en);
      chk({tag, ".done_total"},  ndone, 1);
    end
  endtask

  initial begin
    //          ts      ton      tg     num  rev inj abort busy  en
    vecs[0] = '{12'd2, 12'd3,    12'd1, 3'd2, 0, -1, -1,   10,    6};
    vecs[1] = '{12'd0, 12'd2,    12'd0, 3'd4, 1, -1, -1,    9,    8};
    vecs[2] = '{12'd0, 12'd0,    12'd0, 3'd0, 0, -1, -1,    2,    1};
    vecs[3] = '{12'd1, 12'd1,    12'd2, 3'd7, 0, 12, -1,   12,    4};
    vecs[4] = '{12'd1, 12'd4,    12'd1, 3'd3, 0,  4, -1,   16,   12};
    vecs[5] = '{12'd3, 12'd1,    12'd0, 3'd3, 1, -1, -1,    7,    3};
    vecs[6] = '{12'd1, 12'd2,    12'd3, 3'd2, 0, -1,  5,   -1,   -1};
    vecs[7] = '{12'd0, 12'd1,    12'd1, 3'd2, 0, -1, -1,    4,    2};
    vecs[8] = '{12'd0, 12'd4095, 12'd0, 3'd1, 0, -1, -1, 4096, 4095};

    rst            = 1'b1;
    bus.line_start = 1'b0;
    bus.t_setup    = '0;
    bus.t_on       = '0;
    bus.t_gap      = '0;
    bus.mux_num    = '0;
    bus.reverse    = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check_all_zero("idle");
    end

    for (int v = 0; v < 9; v++) begin
      run_line(vecs[v], v);
      repeat (2) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
